// File: rtl/espi_target_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : espi_target_responder                                         |
// | Purpose  : Target side of a single-IO eSPI-style serial link. Decodes a  |
// |            command byte and an optional data byte from sclk/cs_n/io0,    |
// |            writes a local register file, and returns read data on io0    |
// |            after a one-cycle turnaround. Bus pins are oversampled into   |
// |            clk through SYNC_STAGES-deep synchronizers.                   |
// | Ports    : clk, reset (async, active high)                               |
// |            sclk, cs_n, io0_i       - bus pins from the host              |
// |            io0_o, io0_oe           - target drive value / enable on io0  |
// |            wr_valid/wr_addr/wr_data- committed write report              |
// |            err                     - invalid command / parity pulse      |
// |            busy                    - FSM not in IDLE                     |
// | Config   : ESPI_RESP_PARITY_EN enables an even-parity bit after each data |
// |            byte (checked on writes, driven on reads).                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module espi_target_responder #(
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              io0_i,
   output logic              io0_o,
   output logic              io0_oe,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              err,
   output logic              busy
);

   localparam int REG_DEPTH = 2**ADDR_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      WDATA = 3'd2,
      TAR   = 3'd3,
      RDATA = 3'd4,
`ifdef ESPI_RESP_PARITY_EN
      PAR   = 3'd5,
`endif
      DONE  = 3'd6
   } state_t;

   // ---------------- pin synchronizers and edge strobes ----------------
   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, io_sync;
   logic                   sclk_q, cs_q;
   logic                   sclk_s, cs_s, io_s;
   logic                   sclk_rise, sclk_fall, cs_fall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync <= '0;
         cs_sync   <= '1;   // bus idles deselected
         io_sync   <= '0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         io_sync   <= {io_sync[SYNC_STAGES-2:0], io0_i};
         sclk_q    <= sclk_sync[SYNC_STAGES-1];
         cs_q      <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign io_s      = io_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s & sclk_q;
   assign cs_fall   = ~cs_s & cs_q;

   // ---------------- frame FSM ----------------
   state_t            state;
   logic [4:0]        cnt;      // rising sclk edges seen in this frame
   logic [6:0]        cmd_sh;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        shreg;
   logic [7:0]        regs [REG_DEPTH];
   logic [7:0]        cmd_full;
   logic              cmd_bad;
`ifdef ESPI_RESP_PARITY_EN
   logic              rd_par;
`endif

   // Command byte as it stands once the current io sample is shifted in.
   assign cmd_full = {cmd_sh, io_s};
   assign cmd_bad  = (cmd_full[6:4] != 3'b000) ||
                     ((cmd_full[3:0] >> ADDR_W) != 4'd0);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 5'd0;
         cmd_sh   <= 7'd0;
         addr     <= '0;
         shreg    <= 8'h00;
         io0_o    <= 1'b0;
         io0_oe   <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= 8'h00;
         err      <= 1'b0;
`ifdef ESPI_RESP_PARITY_EN
         rd_par   <= 1'b0;
`endif
         for (int i = 0; i < REG_DEPTH; i++) regs[i] <= 8'h00;
      end else begin
         wr_valid <= 1'b0;
         err      <= 1'b0;
         // Deselect aborts from any state and beats a coincident sclk strobe.
         if (state != IDLE && cs_s) begin
            state  <= IDLE;
            io0_oe <= 1'b0;
            io0_o  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     state <= CMD;
                     cnt   <= 5'd0;
                  end
               end
               CMD: begin
                  if (sclk_rise) begin
                     cnt    <= cnt + 5'd1;
                     cmd_sh <= cmd_full[6:0];
                     if (cnt == 5'd7) begin
                        addr <= cmd_full[ADDR_W-1:0];
                        if (cmd_bad) begin
                           err   <= 1'b1;
                           state <= DONE;
                        end else if (cmd_full[7]) begin
                           state <= TAR;
                        end else begin
                           state <= WDATA;
                        end
                     end
                  end
               end
               WDATA: begin
                  if (sclk_rise) begin
                     cnt   <= cnt + 5'd1;
                     shreg <= {shreg[6:0], io_s};
`ifdef ESPI_RESP_PARITY_EN
                     // Edge 17 carries the parity bit; shreg holds the full byte.
                     if (cnt == 5'd16) begin
                        if (io_s == ^shreg) begin
                           regs[addr] <= shreg;
                           wr_addr    <= addr;
                           wr_data    <= shreg;
                           wr_valid   <= 1'b1;
                        end else begin
                           err <= 1'b1;
                        end
                        state <= DONE;
                     end
`else
                     if (cnt == 5'd15) begin
                        regs[addr] <= {shreg[6:0], io_s};
                        wr_addr    <= addr;
                        wr_data    <= {shreg[6:0], io_s};
                        wr_valid   <= 1'b1;
                        state      <= DONE;
                     end
`endif
                  end
               end
               TAR: begin
                  // Edge 9 is the turnaround; the following fall starts driving.
                  if (sclk_rise) begin
                     cnt <= cnt + 5'd1;
                  end else if (sclk_fall && cnt == 5'd9) begin
                     shreg  <= regs[addr];
                     io0_o  <= regs[addr][7];
                     io0_oe <= 1'b1;
`ifdef ESPI_RESP_PARITY_EN
                     rd_par <= ^regs[addr];
`endif
                     state  <= RDATA;
                  end
               end
               RDATA: begin
                  if (sclk_rise) begin
                     cnt <= cnt + 5'd1;
                     if (cnt == 5'd16) begin
`ifdef ESPI_RESP_PARITY_EN
                        state <= PAR;
`else
                        state <= DONE;
`endif
                     end
                  end else if (sclk_fall) begin
                     shreg <= {shreg[6:0], 1'b0};
                     io0_o <= shreg[6];
                  end
               end
`ifdef ESPI_RESP_PARITY_EN
               PAR: begin
                  if (sclk_rise) begin
                     state <= DONE;
                  end else if (sclk_fall) begin
                     io0_o <= rd_par;
                  end
               end
`endif
               DONE: begin
                  if (sclk_fall) io0_oe <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_espi_target_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_espi_target_responder                                      |
// | Purpose  : Directed scoreboard bench for espi_target_responder. A host   |
// |            task drives frames and queues the expected responses; monitor |
// |            processes pop and compare on wr_valid, err and frame end.     |
// | Config   : ESPI_RESP_PARITY_EN adds the parity frames.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_espi_target_responder;

   localparam int ADDR_W      = 4;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 80;   // sclk half period, 8 clk
`ifdef ESPI_RESP_PARITY_EN
   localparam int WR_EDGES = 17;
   localparam int RD_EDGES = 18;
   localparam int RD_BITS  = 9;
`else
   localparam int WR_EDGES = 16;
   localparam int RD_EDGES = 17;
   localparam int RD_BITS  = 8;
`endif
   localparam int K_WR  = 0;
   localparam int K_ERR = 1;
   localparam int K_RD  = 2;

   logic              clk   = 1'b0;
   logic              reset = 1'b1;
   logic              sclk  = 1'b0;
   logic              cs_n  = 1'b1;
   logic              io0_i = 1'b0;
   logic              io0_o, io0_oe, wr_valid, err, busy;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   espi_target_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk      (clk),
      .reset    (reset),
      .sclk     (sclk),
      .cs_n     (cs_n),
      .io0_i    (io0_i),
      .io0_o    (io0_o),
      .io0_oe   (io0_oe),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .err      (err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int addr;
      int data;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic push(input int kind, input int addr, input int data);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      q.push_back(e);
   endtask

   // Expected host-side read pattern: data byte, then even parity if enabled.
   function automatic int rd_exp(input logic [7:0] d);
`ifdef ESPI_RESP_PARITY_EN
      return int'({d, ^d});
`else
      return int'(d);
`endif
   endfunction

   // Write / error monitor.
   always @(negedge clk) begin : wr_mon
      exp_t e;
      if (!reset && (wr_valid === 1'b1 || err === 1'b1)) begin
         if (q.size() == 0) begin
            check(wr_valid === 1'b1 ? "unexpected_wr" : "unexpected_err", 1, 0);
         end else begin
            e = q.pop_front();
            if (wr_valid === 1'b1) begin
               check("wr_kind", e.kind, K_WR);
               check("wr_addr", wr_addr, e.addr);
               check("wr_data", wr_data, e.data);
               check("wr_no_err", err, 0);
            end else begin
               check("err_kind", e.kind, K_ERR);
            end
         end
      end
   end

   // Host-side read capture: samples io0 on rising sclk while the target drives.
   logic [8:0] cap     = 9'd0;
   int         cap_cnt = 0;
   always @(posedge sclk or posedge cs_n or posedge reset) begin : rd_mon
      exp_t e;
      if (reset) begin
         cap_cnt = 0;
         cap     = 9'd0;
      end else if (cs_n) begin
         if (cap_cnt != 0) begin
            if (q.size() == 0) begin
               check("unexpected_read", 1, 0);
            end else begin
               e = q.pop_front();
               check("rd_kind", e.kind, K_RD);
               check("rd_bits", cap_cnt, RD_BITS);
               check("rd_data", {23'd0, cap}, e.data);
            end
         end
         cap_cnt = 0;
         cap     = 9'd0;
      end else if (io0_oe === 1'b1) begin
         cap = {cap[7:0], io0_o};
         cap_cnt++;
      end
   end

   // One host frame: cmd, data, parity bit; stops after `edges` rising edges.
   // rst_at > 0 asserts reset just after that rising edge and ends the frame.
   task automatic frame(input logic [7:0] cmd, input logic [7:0] data, input logic par,
                        input int edges, input int rst_at);
      logic [16:0] bits;
      bits  = {cmd, data, par};
      cs_n  = 1'b0;
      io0_i = bits[16];
      #(HALF);
      check("busy_in_frame", busy, 1);
      for (int k = 1; k <= edges; k++) begin
         sclk = 1'b1;
         if (k == rst_at) begin
            #1 reset = 1'b1;
            #1;
            check("rst_io0_oe", io0_oe, 0);
            check("rst_io0_o", io0_o, 0);
            check("rst_busy", busy, 0);
            check("rst_wr_valid", wr_valid, 0);
            check("rst_wr_addr", wr_addr, 0);
            check("rst_wr_data", wr_data, 0);
            check("rst_err", err, 0);
            #(HALF);
            sclk = 1'b0;
            cs_n = 1'b1;
            #50 reset = 1'b0;
            #(2*HALF);
            return;
         end
         if (k == 9 && cmd[7]) begin
            #(HALF-1);
            check("tar_io0_oe", io0_oe, 0);
            #1;
         end else begin
            #(HALF);
         end
         sclk  = 1'b0;
         io0_i = (k < 17) ? bits[16-k] : 1'b0;
         #(HALF);
      end
      check("end_io0_oe", io0_oe, 0);
      cs_n = 1'b1;
      #(2*HALF);
   endtask

   initial begin : stim
      int n;
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_io0_o", io0_o, 0);
      check("reset_io0_oe", io0_oe, 0);
      check("reset_wr_valid", wr_valid, 0);
      check("reset_wr_addr", wr_addr, 0);
      check("reset_wr_data", wr_data, 0);
      check("reset_err", err, 0);
      check("reset_busy", busy, 0);

      // Write 0xA5 to reg 3, then read it back.
      push(K_WR, 3, 'hA5);
      frame(8'h03, 8'hA5, ^8'hA5, WR_EDGES, 0);
      push(K_RD, 3, rd_exp(8'hA5));
      frame(8'h83, 8'h00, 1'b0, RD_EDGES, 0);

      // Abort a write to reg 5 after 4 data bits.
      frame(8'h05, 8'h5A, 1'b0, 12, 0);
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("abort_busy", busy, 0);
      check("abort_io0_oe", io0_oe, 0);
      push(K_RD, 5, rd_exp(8'h00));
      frame(8'h85, 8'h00, 1'b0, RD_EDGES, 0);

      // Invalid commands: reserved bits set (write- and read-shaped).
      push(K_ERR, 0, 0);
      frame(8'h40, 8'h00, 1'b0, WR_EDGES, 0);
      push(K_ERR, 0, 0);
      frame(8'h90, 8'h00, 1'b0, RD_EDGES, 0);
      push(K_WR, 14, 'h5A);
      frame(8'h0E, 8'h5A, ^8'h5A, WR_EDGES, 0);
      push(K_RD, 14, rd_exp(8'h5A));
      frame(8'h8E, 8'h00, 1'b0, RD_EDGES, 0);

      // Reset in the middle of reading 0xFF.
      push(K_WR, 2, 'hFF);
      frame(8'h02, 8'hFF, ^8'hFF, WR_EDGES, 0);
      frame(8'h82, 8'h00, 1'b0, RD_EDGES, 12);
      push(K_WR, 1, 'h3C);
      frame(8'h01, 8'h3C, ^8'h3C, WR_EDGES, 0);
      push(K_RD, 1, rd_exp(8'h3C));
      frame(8'h81, 8'h00, 1'b0, RD_EDGES, 0);
      push(K_RD, 2, rd_exp(8'h00));
      frame(8'h82, 8'h00, 1'b0, RD_EDGES, 0);

`ifdef ESPI_RESP_PARITY_EN
      // Bad parity, good parity, then read parity back.
      push(K_ERR, 0, 0);
      frame(8'h07, 8'h3C, 1'b1, WR_EDGES, 0);
      push(K_RD, 7, rd_exp(8'h00));
      frame(8'h87, 8'h00, 1'b0, RD_EDGES, 0);
      push(K_WR, 7, 'h3C);
      frame(8'h07, 8'h3C, 1'b0, WR_EDGES, 0);
      push(K_RD, 7, rd_exp(8'h3C));
      frame(8'h87, 8'h00, 1'b0, RD_EDGES, 0);
`endif

      repeat (20) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
